// File: rtl/board_color_streamer.sv
// Snapshots a ROWS x COLS board of piece codes on frame_start and streams one row of
// palette colours per valid/ready handshake, with a run-time writable palette and blinking cells.
module board_color_streamer #(
  parameter int unsigned       ROWS       = 12,
  parameter int unsigned       COLS       = 10,
  parameter int unsigned       CODE_W     = 4,
  parameter int unsigned       COLOR_W    = 8,
  parameter logic [CODE_W-1:0] FLASH_CODE = 4'hF,
  parameter int unsigned       BLINK_DIV  = 25_000_000
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [ROWS*COLS*CODE_W-1:0]               board,
  input  logic                                      frame_start,
  input  logic                                      pal_we,
  input  logic [CODE_W-1:0]                         pal_addr,
  input  logic [COLOR_W-1:0]                        pal_wdata,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [COLS*COLOR_W-1:0]                   out_colors,
  output logic                                      out_last,
  output logic                                      busy
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned DEPTH = 1 << CODE_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state, state_n;
  logic [COLOR_W-1:0]            pal [DEPTH];
  logic [ROWS*COLS*CODE_W-1:0]   snap, src;
  logic                          frame_phase, phase, ph;
  logic [CNT_W-1:0]              blink_cnt;
  logic                          valid_n, last_n, busy_n, load, snap_load;
  logic [ROW_W-1:0]              row_n, load_row;
  logic [COLS*COLOR_W-1:0]       colors_n;
  logic [CODE_W-1:0]             code;
  int unsigned                   row_base;

  function automatic logic [COLOR_W-1:0] pal_default(input int unsigned idx);
    logic [7:0] c;
    case (idx)
      1:       c = 8'hF0;
      2:       c = 8'hF9;
      3:       c = 8'h14;
      4:       c = 8'h7F;
      5:       c = 8'h4F;
      6:       c = 8'h8F;
      7:       c = 8'hF3;
      8:       c = 8'hC0;
      15:      c = 8'h92;
      default: c = 8'h00;
    endcase
    return COLOR_W'(c);
  endfunction

  // Free-running blink phase, independent of the streaming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pal[i] <= pal_default(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap        <= '0;
      frame_phase <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_colors  <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state      <= state_n;
      out_valid  <= valid_n;
      out_row    <= row_n;
      out_colors <= colors_n;
      out_last   <= last_n;
      busy       <= busy_n;
      if (snap_load) begin
        snap        <= board;
        frame_phase <= phase;
      end
    end
  end

  // Row 0 is coloured straight from the live board/phase because the snapshot
  // registers are only being written at that same edge.
  always_comb begin
    state_n   = state;
    valid_n   = out_valid;
    row_n     = out_row;
    last_n    = out_last;
    busy_n    = busy;
    colors_n  = out_colors;
    load      = 1'b0;
    snap_load = 1'b0;
    load_row  = '0;
    src       = snap;
    ph        = frame_phase;
    code      = '0;
    row_base  = 0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          snap_load = 1'b1;
          load      = 1'b1;
          src       = board;
          ph        = phase;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_last) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            load     = 1'b1;
            load_row = out_row + ROW_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      row_n    = load_row;
      last_n   = (load_row == ROW_W'(ROWS - 1));
      row_base = 32'(load_row) * COLS;
      for (int unsigned c = 0; c < COLS; c++) begin
        code = src[(row_base + c)*CODE_W +: CODE_W];
        colors_n[c*COLOR_W +: COLOR_W] = (code == FLASH_CODE && ph) ? '0 : pal[code];
      end
    end
  end

endmodule

// File: tb/tb_board_color_streamer.sv
// Scoreboard bench for board_color_streamer: stimulus queues expected beats, a negedge monitor checks them.
module tb_board_color_streamer;

  localparam int ROWS = 12;
  localparam int COLS = 10;

  typedef struct {
    logic [3:0]  row;
    logic [79:0] colors;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [479:0] board;
  logic         frame_start, pal_we, out_ready;
  logic [3:0]   pal_addr;
  logic [7:0]   pal_wdata;
  logic         out_valid, out_last, busy;
  logic [3:0]   out_row;
  logic [79:0]  out_colors;

  int    errors = 0;
  int    checks = 0;
  beat_t sb[$];

  logic [1:0]  mcnt;
  logic        mph;
  logic        hold;
  logic [3:0]  h_row;
  logic [79:0] h_col;

  always #5 clk = ~clk;

  board_color_streamer #(.BLINK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .board(board), .frame_start(frame_start),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_colors(out_colors), .out_last(out_last), .busy(busy)
  );

  // Reference blink phase: half-period of 4 cycles from reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 2'd0;
      mph  <= 1'b0;
    end else if (mcnt == 2'd3) begin
      mcnt <= 2'd0;
      mph  <= ~mph;
    end else begin
      mcnt <= mcnt + 2'd1;
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 80'(out_valid), 80'(1));
        chk("hold_row", 80'(out_row), 80'(h_row));
        chk("hold_colors", out_colors, h_col);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got row %0d expected no beat", out_row);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_row", 80'(out_row), 80'(e.row));
          chk("beat_colors", out_colors, e.colors);
          chk("beat_last", 80'(out_last), 80'(e.last));
        end
      end
      hold  = out_valid && !out_ready;
      h_row = out_row;
      h_col = out_colors;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [479:0] fill(input logic [3:0] code);
    return {120{code}};
  endfunction

  task automatic push_row(input int r, input logic [79:0] cols);
    beat_t b;
    b.row    = 4'(r);
    b.colors = cols;
    b.last   = (r == ROWS - 1);
    sb.push_back(b);
  endtask

  task automatic push_uniform(input logic [7:0] c);
    for (int r = 0; r < ROWS; r++) push_row(r, {10{c}});
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, sb.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] ev;
    logic [3:0]  pat [10];
    frame_start = 1'b0;
    pal_we      = 1'b0;
    pal_addr    = 4'd0;
    pal_wdata   = 8'd0;
    out_ready   = 1'b1;
    board       = fill(4'd3);
    hold        = 1'b0;

    #12;
    chk("rst_valid", 80'(out_valid), 80'(0));
    chk("rst_row", 80'(out_row), 80'(0));
    chk("rst_colors", out_colors, 80'(0));
    chk("rst_last", 80'(out_last), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Test 1: board all 3 streams 12 beats of 8'h14
    push_uniform(8'h14);
    start_frame();
    chk("t1_valid_lat1", 80'(out_valid), 80'(1));
    chk("t1_busy_on", 80'(busy), 80'(1));
    repeat (11) step();
    chk("t1_last_row11", 80'(out_last), 80'(1));
    chk("t1_busy_at_last", 80'(busy), 80'(1));
    step();
    chk("t1_busy_off", 80'(busy), 80'(0));
    chk("t1_valid_off", 80'(out_valid), 80'(0));
    wait_idle("t1");

    // Test 2: backpressure pattern 1,0,0,1
    board = fill(4'd1);
    push_uniform(8'hF0);
    start_frame();
    for (int k = 0; k < 200 && (sb.size() != 0 || busy); k++) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    out_ready = 1'b1;
    wait_idle("t2");

    // Test 3: palette entry 2 rewritten at the edge that loads row 5
    board = fill(4'd2);
    for (int r = 0; r < ROWS; r++) push_row(r, (r <= 5) ? {10{8'hF9}} : {10{8'hAA}});
    start_frame();
    repeat (4) step();
    pal_we    = 1'b1;
    pal_addr  = 4'd2;
    pal_wdata = 8'hAA;
    step();
    pal_we = 1'b0;
    wait_idle("t3");

    // Test 6: board change after snapshot has no effect
    board = fill(4'd3);
    push_uniform(8'h14);
    start_frame();
    board = fill(4'd5);
    wait_idle("t6");

    // Test 4: flashing cells, frame_start pulses every 10 cycles; odd pulses hit a busy frame
    board = fill(4'hF);
    for (int p = 0; p < 6; p++) begin
      if (p % 2 == 0) push_uniform(mph ? 8'h00 : 8'h92);
      start_frame();
      repeat (9) step();
    end
    wait_idle("t4");

    // Test 5: asynchronous reset while row 5 is presented
    board = fill(4'd3);
    push_uniform(8'h14);
    start_frame();
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid_async", 80'(out_valid), 80'(0));
    chk("t5_busy_async", 80'(busy), 80'(0));
    chk("t5_row_async", 80'(out_row), 80'(0));
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("t5_no_beats", 80'(out_valid), 80'(0));

    // Palette readback: columns carry codes 0..8 and F
    pat = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[(r*COLS + c)*4 +: 4] = pat[c];
    ev = {(mph ? 8'h00 : 8'h92), 8'hC0, 8'hF3, 8'h8F, 8'h4F, 8'h7F, 8'h14, 8'hF9, 8'hF0, 8'h00};
    for (int r = 0; r < ROWS; r++) push_row(r, ev);
    start_frame();
    wait_idle("t5_readback");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
